// File: rtl/sar_compare_search_if.sv
// rtl/sar_compare_search_if.sv - comparator-side handshake bundle for the SAR search controller
interface sar_compare_search_if #(
  parameter int N = 32
);
  logic         start;
  logic         Lesser;
  logic         Greater;
  logic         Equal;
  logic [N-1:0] probe;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         err;

  // The search controller: drives the probe, consumes comparator flags.
  modport master (
    input  start, Lesser, Greater, Equal,
    output probe, busy, done, result, err
  );

  // The requester/comparator side.
  modport slave (
    output start, Lesser, Greater, Equal,
    input  probe, busy, done, result, err
  );
endinterface

// File: rtl/sar_compare_search.sv
// rtl/sar_compare_search.sv - successive-approximation search over a comparator (optional SAR_EARLY_EXIT_EN)
module sar_compare_search #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sar_compare_search_if.master bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   result_q, result_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           err_q, err_d;

  logic [N-1:0]   bit_mask;
  logic [N-1:0]   candidate;
  logic           flags_onehot;

  // Trial value for this cycle: bits already decided plus the bit under test.
  // Bits below idx are always zero, so the OR can never carry or overflow.
  assign bit_mask     = N'(1) << idx_q;
  assign candidate    = result_q | bit_mask;
  assign flags_onehot = ({bus.Lesser, bus.Greater, bus.Equal} == 3'b100) ||
                        ({bus.Lesser, bus.Greater, bus.Equal} == 3'b010) ||
                        ({bus.Lesser, bus.Greater, bus.Equal} == 3'b001);

  // State and datapath registers; async reset returns everything to idle zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  // Next-state: one result bit decided per SEARCH cycle, MSB first.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    idx_d    = idx_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          result_d = '0;
          idx_d    = IW'(N - 1);
          err_d    = 1'b0;
          state_d  = SEARCH;
        end
      end
      SEARCH: begin
        if (!flags_onehot) begin
          // Inconsistent comparator: abandon the search, report nothing found.
          err_d    = 1'b1;
          result_d = '0;
          state_d  = DONE;
        end
`ifdef SAR_EARLY_EXIT_EN
        else if (bus.Equal) begin
          result_d = candidate;
          state_d  = DONE;
        end
`endif
        else begin
          // Greater means the trial bit overshoots; otherwise keep it.
          if (!bus.Greater) begin
            result_d = candidate;
          end
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: probe carries the trial value only while searching.
  always_comb begin
    bus.probe  = (state_q == SEARCH) ? candidate : result_q;
    bus.busy   = (state_q != IDLE);
    bus.done   = (state_q == DONE);
    bus.result = result_q;
    bus.err    = err_q;
  end

endmodule

// File: tb/tb_sar_compare_search.sv
// tb/tb_sar_compare_search.sv - table-driven scoreboard bench for sar_compare_search
module tb_sar_compare_search;

  localparam int N = 32;

  logic        clk;
  logic        rst_n;
  logic [31:0] target;
  logic        inj;

  int n_checks;
  int n_errors;

  sar_compare_search_if #(.N(N)) bus ();

  sar_compare_search #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Comparator model, with an override that asserts two flags at once.
  assign bus.Lesser  = inj ? 1'b1 : (bus.probe <  target);
  assign bus.Greater = inj ? 1'b1 : (bus.probe >  target);
  assign bus.Equal   = inj ? 1'b0 : (bus.probe == target);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    int          inject;   // SEARCH cycle that sees Lesser=Greater=1, 0 = none
    int          restart;  // SEARCH cycle that re-pulses start, 0 = none
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    logic [31:0] last_probe;
    logic        chk_last;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int search_cycles(input logic [31:0] t);
`ifdef SAR_EARLY_EXIT_EN
    for (int b = 0; b < 32; b++) begin
      if (t[b]) return 32 - b;
    end
`endif
    return 32;
  endfunction

  function automatic logic [31:0] final_probe(input logic [31:0] t);
`ifdef SAR_EARLY_EXIT_EN
    if (t != 0) return t;
`endif
    return t | 32'h1;
  endfunction

  task automatic run_search(input vec_t v);
    exp_t        e;
    exp_t        got;
    int          cnt;
    logic [31:0] last_p;
    logic        timed_out;

    target = v.target;
    e.res        = (v.inject != 0) ? 32'h0 : v.target;
    e.err        = (v.inject != 0);
    e.lat        = (v.inject != 0) ? v.inject + 1 : search_cycles(v.target) + 1;
    e.last_probe = final_probe(v.target);
    e.chk_last   = (v.inject == 0);
    sb_q.push_back(e);

    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("first_probe", bus.probe, 32'h8000_0000);
    check("busy_on_start", {31'h0, bus.busy}, 32'h1);
    check("err_cleared", {31'h0, bus.err}, 32'h0);

    cnt       = 0;
    last_p    = 32'h0;
    timed_out = 1'b0;
    while (!bus.done) begin
      last_p    = bus.probe;
      inj       = (v.inject != 0) && (cnt == v.inject - 1);
      bus.start = (v.restart != 0) && (cnt == v.restart - 1);
      @(posedge clk);
      #1;
      cnt++;
      if (cnt > 100) begin
        timed_out = 1'b1;
        break;
      end
    end
    inj       = 1'b0;
    bus.start = 1'b0;

    got = sb_q.pop_front();
    if (timed_out) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: no done within 100 cycles for target 0x%08h", v.target);
    end else begin
      check("result", bus.result, got.res);
      check("err", {31'h0, bus.err}, {31'h0, got.err});
      check("latency", cnt + 1, got.lat);
      if (got.chk_last) check("last_probe", last_p, got.last_probe);
      @(posedge clk);
      #1;
      check("done_one_cycle", {31'h0, bus.done}, 32'h0);
      check("idle_after_done", {31'h0, bus.busy}, 32'h0);
      check("result_held", bus.result, got.res);
    end
  endtask

  vec_t vecs[9];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    target    = 32'h0;
    inj       = 1'b0;
    bus.start = 1'b0;
    rst_n     = 1'b0;

    vecs[0] = '{32'd444,        0, 0};
    vecs[1] = '{32'h0000_0000,  0, 0};
    vecs[2] = '{32'hFFFF_FFFF,  0, 0};
    vecs[3] = '{32'h8000_0000,  0, 0};
    vecs[4] = '{32'd444,        5, 0};
    vecs[5] = '{32'd1234,       0, 0};
    vecs[6] = '{32'd777,        0, 10};
    vecs[7] = '{32'h5A5A_5A5A,  0, 0};
    vecs[8] = '{32'h0000_0001,  0, 0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   {31'h0, bus.busy}, 32'h0);
    check("rst_done",   {31'h0, bus.done}, 32'h0);
    check("rst_err",    {31'h0, bus.err},  32'h0);
    check("rst_result", bus.result, 32'h0);
    check("rst_probe",  bus.probe,  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_stays", {31'h0, bus.busy}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      run_search(vecs[i]);
    end

    // Reset in the middle of a search: outputs drop at once, no done pulse.
    target = 32'd777;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   {31'h0, bus.busy}, 32'h0);
    check("midrst_probe",  bus.probe,  32'h0);
    check("midrst_result", bus.result, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("midrst_no_done", {31'h0, bus.done}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {31'h0, bus.busy}, 32'h0);
    run_search('{32'd8888, 0, 0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sar_compare_search.md
Name: sar_compare_search

Overview:
- Successive-approximation search controller: the driving end of the N-bit magnitude comparator interface.
- Drives a probe word into the comparator's `a` operand; the unknown target sits on `b`.
- Consumes the Lesser/Greater/Equal flags and binary-searches the target value, one bit per cycle, MSB first.
- Used wherever a value is only observable through a comparator (threshold discovery, SAR-style conversion).

Parameters:
- N, 32, operand width of probe and result.
- IW, $clog2(N), width of the internal bit-index counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a search; honoured only in IDLE.
- Lesser  input  1  comparator flag: probe < target.
- Greater  input  1  comparator flag: probe > target.
- Equal  input  1  comparator flag: probe == target.
- probe  output  N  operand driven to comparator input `a`.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when a search completes.
- result  output  N  found target value; held until the next start.
- err  output  1  flag-consistency error for the last search; cleared on start.

Behaviour:
- Reset (async, rst_n low): state=IDLE, result=0, idx=0, busy=0, done=0, err=0, probe=0.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - start=1 at edge k: result<=0, idx<=N-1, err<=0, state<=SEARCH.
  - start=0: remain in IDLE.
- SEARCH:
  - probe = result | (1<<idx), combinational from registers and stable for the whole cycle.
  - Comparator is combinational, so flags are sampled at the next rising edge.
  - Flags exactly one-hot and Greater=1: bit idx of result stays 0.
  - Flags exactly one-hot and Lesser=1 or Equal=1: bit idx of result <= 1.
  - idx==0: state<=DONE; otherwise idx<=idx-1.
  - Flags not exactly one-hot (zero or more than one set): err<=1, result<=0, state<=DONE immediately.
- DONE: done=1 for exactly one cycle; state<=IDLE.
- Outside SEARCH: probe = result.
- busy=1 in SEARCH and DONE; 0 in IDLE.
- Latency: start sampled at edge k -> N SEARCH cycles -> done high in the cycle after edge k+N. Total N+1 cycles from start to done.
- start while busy: ignored, with no effect on the running search.
- start in the same cycle done is high: ignored; a new start is accepted only in IDLE.
- Boundaries:
  - target=0 -> every probe reports Greater, result=0.
  - target=2^N-1 -> final probe reports Equal, result=all ones.
  - No overflow is possible: probe bits below idx are always 0.
- Reset mid-search: immediate return to IDLE with all outputs at reset values; no done pulse is generated.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- Defined: in SEARCH, a one-hot Equal=1 loads result<=probe and goes to DONE that cycle; the search takes between 1 and N cycles.
- Not defined: Equal is treated like Lesser, and every search takes exactly N SEARCH cycles.
- The err logic is identical in both builds.

Test Plan:
- Bench models the comparator against a target register.
- Target=444, N=32, start pulse -> probe 0x80000000 first with Greater=1; done exactly 33 cycles after start; result=444; err=0.
- Target=0, then target=0xFFFFFFFF -> result 0 and 0xFFFFFFFF respectively, each with a 33-cycle latency; last probe 0x00000001 and 0xFFFFFFFF respectively.
- SAR_EARLY_EXIT_EN defined, target=0x80000000 -> Equal on the first probe; done 2 cycles after start; result=0x80000000.
- Force Lesser=Greater=1 on the 5th SEARCH cycle -> err=1, result=0, done on the next cycle; a following start clears err.
- start re-pulsed at SEARCH cycle 10 of a target=777 search -> ignored, result=777 at the normal cycle. Then rst_n low mid-search -> busy=0, probe=0, no done pulse; a fresh start after release finds target 8888.
